// File: rtl/wb_commit_queue_if.sv
// Bundle between the MEM stage, the writeback commit queue and its consumers
// (regfile, flush control, forwarding lookups and debug trace).
interface wb_commit_queue_if #(
  parameter int unsigned COMMIT_W  = 1,
  parameter int unsigned FWD_PORTS = 2
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_result;
  logic [4:0]               in_dest;
  logic                     in_gr_we;
  logic                     in_ex;
  logic [5:0]               in_ecode;
  logic                     in_ertn;
  logic                     commit_stall;

  logic [COMMIT_W-1:0]      rf_we;
  logic [5*COMMIT_W-1:0]    rf_waddr;
  logic [32*COMMIT_W-1:0]   rf_wdata;

  logic                     flush;
  logic                     flush_ertn;
  logic [5:0]               flush_ecode;
  logic [31:0]              flush_pc;

  logic [5*FWD_PORTS-1:0]   fwd_addr;
  logic [FWD_PORTS-1:0]     fwd_hit;
  logic [32*FWD_PORTS-1:0]  fwd_data;

  logic [63:0]              retired_cnt;

  logic [32*COMMIT_W-1:0]   debug_wb_pc;
  logic [4*COMMIT_W-1:0]    debug_wb_rf_wen;
  logic [5*COMMIT_W-1:0]    debug_wb_rf_wnum;
  logic [32*COMMIT_W-1:0]   debug_wb_rf_wdata;

  // Upstream/consumer side
  modport master (
    output in_valid, in_pc, in_result, in_dest, in_gr_we, in_ex, in_ecode, in_ertn,
    output commit_stall, fwd_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
    input  flush, flush_ertn, flush_ecode, flush_pc,
    input  fwd_hit, fwd_data, retired_cnt,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  // Queue side
  modport slave (
    input  in_valid, in_pc, in_result, in_dest, in_gr_we, in_ex, in_ecode, in_ertn,
    input  commit_stall, fwd_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata,
    output flush, flush_ertn, flush_ecode, flush_pc,
    output fwd_hit, fwd_data, retired_cnt,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

endinterface

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: in-order FIFO between MEM and the regfile, retiring up
// to COMMIT_W entries per cycle, reporting exceptions/ERTN and forwarding results.
module wb_commit_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned COMMIT_W  = 1,
  parameter int unsigned FWD_PORTS = 2
) (
  input  logic             clk,
  input  logic             reset,
  wb_commit_queue_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       retired_q, retired_d;

  entry_t            slot_e [2];
  logic [1:0]        ret_c;
  logic [1:0]        wen_c;
  logic [1:0]        pops_c;
  logic              flush_c;
  logic              ready_c;
  logic              push_c;

  // Retire decision for the head entry and, when dual-issue retire is built, head+1
  always_comb begin
    slot_e[0] = ent_q[head_q];
    slot_e[1] = ent_q[head_q + PTR_W'(1)];
    ret_c     = '0;
    wen_c     = '0;
    ret_c[0]  = !reset && (count_q != '0) && !bus.commit_stall;
    if (COMMIT_W == 2) begin
      ret_c[1] = ret_c[0] && (count_q >= CNT_W'(2)) &&
                 !slot_e[0].ex && !slot_e[0].ertn &&
                 !slot_e[1].ex && !slot_e[1].ertn;
    end
    for (int k = 0; k < 2; k++) begin
      wen_c[k] = ret_c[k] && slot_e[k].gr_we && !slot_e[k].ex &&
                 !slot_e[k].ertn && (slot_e[k].dest != 5'd0);
    end
    // Younger slot owns the register when both target the same one
    if (wen_c[0] && wen_c[1] && (slot_e[0].dest == slot_e[1].dest)) begin
      wen_c[0] = 1'b0;
    end
    flush_c = ret_c[0] && (slot_e[0].ex || slot_e[0].ertn);
    pops_c  = {1'b0, ret_c[0]} + {1'b0, ret_c[1]};
    ready_c = (count_q < CNT_W'(DEPTH));
    push_c  = bus.in_valid && ready_c && !flush_c;
  end

  // Pointer, occupancy and counter next state
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    vld_d     = vld_q;
    retired_d = retired_q + 64'(ret_c[0] && !flush_c) + 64'(ret_c[1]);
    if (flush_c) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      vld_d   = '0;
    end else begin
      if (ret_c[0]) vld_d[head_q] = 1'b0;
      if (ret_c[1]) vld_d[head_q + PTR_W'(1)] = 1'b0;
      if (push_c)   vld_d[tail_q] = 1'b1;
      head_d  = head_q + PTR_W'(pops_c);
      tail_d  = tail_q + PTR_W'(push_c);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pops_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      retired_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      vld_q     <= vld_d;
      retired_q <= retired_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld_q/count_q
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      ent_q[tail_q] <= '{pc:     bus.in_pc,
                         result: bus.in_result,
                         dest:   bus.in_dest,
                         gr_we:  bus.in_gr_we,
                         ex:     bus.in_ex,
                         ecode:  bus.in_ecode,
                         ertn:   bus.in_ertn};
    end
  end

  // Regfile, flush, debug trace and counter outputs
  always_comb begin
    bus.in_ready          = ready_c;
    bus.retired_cnt       = retired_q;
    bus.flush             = flush_c;
    bus.flush_ertn        = flush_c && slot_e[0].ertn;
    bus.flush_ecode       = flush_c ? slot_e[0].ecode : 6'd0;
    bus.flush_pc          = flush_c ? slot_e[0].pc : 32'd0;
    bus.rf_we             = '0;
    bus.rf_waddr          = '0;
    bus.rf_wdata          = '0;
    bus.debug_wb_pc       = '0;
    bus.debug_wb_rf_wen   = '0;
    bus.debug_wb_rf_wnum  = '0;
    bus.debug_wb_rf_wdata = '0;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      bus.rf_we[k] = wen_c[k];
      if (ret_c[k]) begin
        bus.rf_waddr[k*5 +: 5]           = slot_e[k].dest;
        bus.rf_wdata[k*32 +: 32]         = slot_e[k].result;
        bus.debug_wb_pc[k*32 +: 32]      = slot_e[k].pc;
        bus.debug_wb_rf_wnum[k*5 +: 5]   = slot_e[k].dest;
        bus.debug_wb_rf_wdata[k*32 +: 32] = slot_e[k].result;
      end
      bus.debug_wb_rf_wen[k*4 +: 4] = {4{wen_c[k]}};
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    bus.fwd_hit  = '0;
    bus.fwd_data = '0;
    for (int p = 0; p < int'(FWD_PORTS); p++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if ((bus.fwd_addr[p*5 +: 5] != 5'd0) &&
            vld_q[head_q + PTR_W'(j)] &&
            ent_q[head_q + PTR_W'(j)].gr_we &&
            !ent_q[head_q + PTR_W'(j)].ex &&
            (ent_q[head_q + PTR_W'(j)].dest == bus.fwd_addr[p*5 +: 5])) begin
          bus.fwd_hit[p]          = 1'b1;
          bus.fwd_data[p*32 +: 32] = ent_q[head_q + PTR_W'(j)].result;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue (DEPTH=4, COMMIT_W=2): directed vector table plus
// random traffic, all checked against a queue-based reference model.
module tb_wb_commit_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned FP    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.COMMIT_W(CW), .FWD_PORTS(FP)) bus ();

  wb_commit_queue #(.DEPTH(DEPTH), .COMMIT_W(CW), .FWD_PORTS(FP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        gr_we;
    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;
    logic [4:0]  fa0;
    logic [4:0]  fa1;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        gr_we;
    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;
  } ment_t;

  typedef struct {
    stim_t       s;
    logic        ready;
    logic [1:0]  we;
    logic        fl;
    logic [63:0] cnt;
    logic [1:0]  hit;
    logic [31:0] fd0;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  ment_t       mq[$];
  logic [63:0] mcnt;
  bit          m_r0, m_r1, m_fl;
  vec_t        tbl[28];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t st(input bit rst, input bit vld, input bit stall,
                               input logic [31:0] pc, input logic [31:0] res,
                               input logic [4:0] dest, input bit gr_we,
                               input bit ex, input bit ertn, input logic [5:0] ecode,
                               input logic [4:0] fa0, input logic [4:0] fa1);
    stim_t s;
    s = '{rst, vld, stall, pc, res, dest, gr_we, ex, ertn, ecode, fa0, fa1};
    return s;
  endfunction

  function automatic vec_t vv(input stim_t s, input bit ready, input logic [1:0] we,
                              input bit fl, input logic [63:0] cnt,
                              input logic [1:0] hit, input logic [31:0] fd0);
    vec_t v;
    v.s = s; v.ready = ready; v.we = we; v.fl = fl; v.cnt = cnt; v.hit = hit; v.fd0 = fd0;
    return v;
  endfunction

  function automatic stim_t idle(input bit stall, input logic [4:0] fa0);
    return st(1'b0, 1'b0, stall, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, fa0, 5'd0);
  endfunction

  task automatic drive(input stim_t s);
    reset            = s.rst;
    bus.in_valid     = s.vld;
    bus.commit_stall = s.stall;
    bus.in_pc        = s.pc;
    bus.in_result    = s.res;
    bus.in_dest      = s.dest;
    bus.in_gr_we     = s.gr_we;
    bus.in_ex        = s.ex;
    bus.in_ertn      = s.ertn;
    bus.in_ecode     = s.ecode;
    bus.fwd_addr     = {s.fa1, s.fa0};
  endtask

  // Expected outputs derived from the queue contents and the retirement rules
  task automatic model_check(input stim_t s);
    int          sz;
    ment_t       e[2];
    logic [1:0]  r, w, hit;
    logic [63:0] dpc, dwd, fd;
    logic [7:0]  dwen;
    logic [9:0]  dnum;
    logic [4:0]  a;
    sz   = mq.size();
    e[0] = (sz > 0) ? mq[0] : '0;
    e[1] = (sz > 1) ? mq[1] : '0;
    r[0] = !s.rst && (sz >= 1) && !s.stall;
    r[1] = r[0] && (sz >= 2) && !e[0].ex && !e[0].ertn && !e[1].ex && !e[1].ertn;
    for (int k = 0; k < 2; k++)
      w[k] = r[k] && e[k].gr_we && !e[k].ex && !e[k].ertn && (e[k].dest != 5'd0);
    if (w == 2'b11 && e[0].dest == e[1].dest) w[0] = 1'b0;
    m_r0 = r[0];
    m_r1 = r[1];
    m_fl = r[0] && (e[0].ex || e[0].ertn);

    chk("in_ready", 64'(bus.in_ready), 64'(sz < DEPTH));
    chk("rf_we", 64'(bus.rf_we), 64'(w));
    dpc = '0; dwd = '0; dwen = '0; dnum = '0;
    for (int k = 0; k < 2; k++) begin
      if (w[k]) begin
        chk("rf_waddr", 64'(bus.rf_waddr[k*5 +: 5]), 64'(e[k].dest));
        chk("rf_wdata", 64'(bus.rf_wdata[k*32 +: 32]), 64'(e[k].res));
      end
      if (r[k]) begin
        dpc[k*32 +: 32] = e[k].pc;
        dwd[k*32 +: 32] = e[k].res;
        dnum[k*5 +: 5]  = e[k].dest;
      end
      dwen[k*4 +: 4] = {4{w[k]}};
    end
    chk("dbg_pc", bus.debug_wb_pc, dpc);
    chk("dbg_wen", 64'(bus.debug_wb_rf_wen), 64'(dwen));
    chk("dbg_wnum", 64'(bus.debug_wb_rf_wnum), 64'(dnum));
    chk("dbg_wdata", bus.debug_wb_rf_wdata, dwd);
    chk("flush_info", 64'({bus.flush, bus.flush_ertn, bus.flush_ecode, bus.flush_pc}),
        m_fl ? 64'({1'b1, e[0].ertn, e[0].ecode, e[0].pc}) : 64'd0);

    hit = '0; fd = '0;
    for (int p = 0; p < 2; p++) begin
      a = (p == 1) ? s.fa1 : s.fa0;
      if (a != 5'd0) begin
        for (int i = sz - 1; i >= 0; i--) begin
          if (mq[i].gr_we && !mq[i].ex && mq[i].dest == a) begin
            hit[p] = 1'b1;
            fd[p*32 +: 32] = mq[i].res;
            break;
          end
        end
      end
    end
    chk("fwd_hit", 64'(bus.fwd_hit), 64'(hit));
    chk("fwd_data", bus.fwd_data, fd);
    chk("retired_cnt", bus.retired_cnt, mcnt);
  endtask

  task automatic model_update(input stim_t s);
    int sz0;
    ment_t n;
    if (s.rst) begin
      mq.delete();
      mcnt = '0;
    end else if (m_fl) begin
      mq.delete();
    end else begin
      sz0 = mq.size();
      if (m_r0) begin void'(mq.pop_front()); mcnt++; end
      if (m_r1) begin void'(mq.pop_front()); mcnt++; end
      if (s.vld && sz0 < DEPTH) begin
        n = '{s.pc, s.res, s.dest, s.gr_we, s.ex, s.ertn, s.ecode};
        mq.push_back(n);
      end
    end
  endtask

  task automatic apply(input stim_t s);
    drive(s);
    #1;
    model_check(s);
  endtask

  task automatic advance(input stim_t s);
    model_update(s);
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    // Directed vectors: fill/stall, same-dest pair, exception flush, forwarding, reset
    tbl[0]  = vv(st(0,1,1,32'h1c000000,32'h101,5'd1,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 0, 2'b00, 0);
    tbl[1]  = vv(st(0,1,1,32'h1c000004,32'h102,5'd2,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 0, 2'b00, 0);
    tbl[2]  = vv(st(0,1,1,32'h1c000008,32'h103,5'd3,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 0, 2'b00, 0);
    tbl[3]  = vv(st(0,1,1,32'h1c00000c,32'h104,5'd4,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 0, 2'b00, 0);
    tbl[4]  = vv(st(0,1,1,32'h1c000010,32'h105,5'd5,1,0,0,6'd0,5'd0,5'd0), 0, 2'b00, 0, 0, 2'b00, 0);
    tbl[5]  = vv(idle(0, 5'd0), 0, 2'b11, 0, 0, 2'b00, 0);
    tbl[6]  = vv(idle(0, 5'd0), 1, 2'b11, 0, 2, 2'b00, 0);
    tbl[7]  = vv(idle(0, 5'd0), 1, 2'b00, 0, 4, 2'b00, 0);
    tbl[8]  = vv(st(0,1,1,32'h1c000000,32'h11,5'd3,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 4, 2'b00, 0);
    tbl[9]  = vv(st(0,1,1,32'h1c000004,32'h22,5'd3,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 4, 2'b00, 0);
    tbl[10] = vv(idle(0, 5'd0), 1, 2'b10, 0, 4, 2'b00, 0);
    tbl[11] = vv(idle(0, 5'd0), 1, 2'b00, 0, 6, 2'b00, 0);
    tbl[12] = vv(st(0,1,1,32'h1c00000c,32'h66,5'd6,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 6, 2'b00, 0);
    tbl[13] = vv(st(0,1,1,32'h1c000010,32'h77,5'd7,1,1,0,6'h08,5'd0,5'd0), 1, 2'b00, 0, 6, 2'b00, 0);
    tbl[14] = vv(st(0,1,1,32'h1c000014,32'h88,5'd8,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 6, 2'b00, 0);
    tbl[15] = vv(idle(0, 5'd0), 1, 2'b01, 0, 6, 2'b00, 0);
    tbl[16] = vv(st(0,1,0,32'h1c000018,32'h99,5'd9,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 1, 7, 2'b00, 0);
    tbl[17] = vv(idle(0, 5'd0), 1, 2'b00, 0, 7, 2'b00, 0);
    tbl[18] = vv(st(0,1,1,32'h1c00001c,32'hAA,5'd5,1,0,0,6'd0,5'd5,5'd0), 1, 2'b00, 0, 7, 2'b00, 0);
    tbl[19] = vv(st(0,1,1,32'h1c000020,32'hBB,5'd5,1,0,0,6'd0,5'd5,5'd0), 1, 2'b00, 0, 7, 2'b01, 32'hAA);
    tbl[20] = vv(idle(1, 5'd5), 1, 2'b00, 0, 7, 2'b01, 32'hBB);
    tbl[21] = vv(idle(0, 5'd5), 1, 2'b10, 0, 7, 2'b01, 32'hBB);
    tbl[22] = vv(idle(0, 5'd5), 1, 2'b00, 0, 9, 2'b00, 0);
    tbl[23] = vv(st(0,1,1,32'h1c000024,32'h1,5'd1,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 9, 2'b00, 0);
    tbl[24] = vv(st(0,1,1,32'h1c000028,32'h2,5'd2,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 9, 2'b00, 0);
    tbl[25] = vv(st(0,1,1,32'h1c00002c,32'h3,5'd3,1,0,0,6'd0,5'd1,5'd0), 1, 2'b00, 0, 9, 2'b01, 32'h1);
    tbl[26] = vv(st(1,1,0,32'h1c000030,32'h4,5'd4,1,0,0,6'd0,5'd0,5'd0), 1, 2'b00, 0, 9, 2'b00, 0);
    tbl[27] = vv(idle(0, 5'd1), 1, 2'b00, 0, 0, 2'b00, 0);

    s = idle(0, 5'd0);
    s.rst = 1'b1;
    drive(s);
    repeat (3) @(negedge clk);
    mq.delete();
    mcnt = '0;

    s = idle(0, 5'd0);
    apply(s);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    chk("rst_dbg_wen", 64'(bus.debug_wb_rf_wen), 64'd0);
    chk("rst_retired_cnt", bus.retired_cnt, 64'd0);
    advance(s);

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].s);
      chk($sformatf("tv%0d_ready", i), 64'(bus.in_ready), 64'(tbl[i].ready));
      chk($sformatf("tv%0d_rf_we", i), 64'(bus.rf_we), 64'(tbl[i].we));
      chk($sformatf("tv%0d_flush", i), 64'(bus.flush), 64'(tbl[i].fl));
      chk($sformatf("tv%0d_retired", i), bus.retired_cnt, tbl[i].cnt);
      chk($sformatf("tv%0d_fwd_hit", i), 64'(bus.fwd_hit), 64'(tbl[i].hit));
      chk($sformatf("tv%0d_fwd_data0", i), 64'(bus.fwd_data[31:0]), 64'(tbl[i].fd0));
      advance(tbl[i].s);
    end

    // Continuous push/retire across pointer wrap
    for (int i = 0; i < 10; i++) begin
      s = st(0, 1, 0, 32'h20000000 + 32'(i*4), 32'h500 + 32'(i), 5'((i % 7) + 1),
             1, 0, 0, 6'd0, 5'd0, 5'd0);
      apply(s);
      advance(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = idle(0, 5'd0);
      apply(s);
      advance(s);
    end

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      s.rst   = ($urandom_range(0, 149) == 0);
      s.vld   = ($urandom_range(0, 9) < 7);
      s.stall = ($urandom_range(0, 3) == 0);
      s.pc    = 32'h1c000000 + 32'(n * 4);
      s.res   = $urandom;
      s.dest  = 5'($urandom_range(0, 7));
      s.gr_we = ($urandom_range(0, 4) != 0);
      s.ex    = ($urandom_range(0, 15) == 0);
      s.ertn  = ($urandom_range(0, 19) == 0);
      s.ecode = 6'($urandom_range(0, 63));
      s.fa0   = 5'($urandom_range(0, 7));
      s.fa1   = 5'($urandom_range(0, 7));
      apply(s);
      advance(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 SHALL have parameter COMMIT_W, default 1, retire slots per cycle; 1 or 2.
REQ-003 SHALL have parameter FWD_PORTS, default 2, forwarding lookup ports.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 in_valid  in  1  upstream (MEM) entry valid.
REQ-007 in_ready  out  1  queue accepts entry this cycle.
REQ-008 in_pc, in_result  in  32 each  instruction PC, writeback value.
REQ-009 in_dest  in  5  destination GPR; in_gr_we  in  1  GPR write request.
REQ-010 in_ex  in  1  exception flagged; in_ecode  in  6  cause; in_ertn  in  1  ERTN instruction.
REQ-011 commit_stall  in  1  suppress all retirement this cycle.
REQ-012 rf_we  out  COMMIT_W; rf_waddr  out  5*COMMIT_W; rf_wdata  out  32*COMMIT_W  regfile ports, slot k at bits [k].
REQ-013 flush  out  1; flush_ertn  out  1; flush_ecode  out  6; flush_pc  out  32  exception/ERTN retirement report.
REQ-014 fwd_addr  in  5*FWD_PORTS; fwd_hit  out  FWD_PORTS; fwd_data  out  32*FWD_PORTS.
REQ-015 retired_cnt  out  64  committed-instruction counter.
REQ-016 debug_wb_pc  out  32*COMMIT_W; debug_wb_rf_wen  out  4*COMMIT_W; debug_wb_rf_wnum  out  5*COMMIT_W; debug_wb_rf_wdata  out  32*COMMIT_W.

Function
REQ-017 SHALL hold a circular FIFO of DEPTH entries, head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH, occupancy count log2(DEPTH)+1 bits.
REQ-018 in_ready SHALL equal (count < DEPTH), independent of same-cycle retirement.
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; simultaneous push and retire SHALL update count by pushes minus retires.
REQ-020 Slot 0 SHALL retire the head entry when count>=1 and !commit_stall.
REQ-021 Slot 1 (COMMIT_W=2) SHALL retire head+1 only when slot 0 retires, count>=2, and neither entry has ex or ertn set.
REQ-022 A retiring entry SHALL drive rf_we=1 only if gr_we && !ex && !ertn && dest!=0.
REQ-023 When both slots write the same dest, slot 0 rf_we SHALL be 0 (slot 1 wins).
REQ-024 Retirement outputs SHALL be combinational from queue head (zero added latency); entries become retirable the cycle after push.
REQ-025 When slot 0 retires an entry with ex or ertn: flush=1 for that cycle, flush_ertn=ertn, flush_ecode=ecode, flush_pc=pc; flush SHALL be 0 otherwise and all flush_* fields 0.
REQ-026 On flush, all entries SHALL be invalidated and pointers/count zeroed next cycle; same-cycle push SHALL be dropped.
REQ-027 commit_stall=1 SHALL force rf_we=0, flush=0, no pop; pushes continue while not full.
REQ-028 fwd_hit[i] SHALL be 1 when fwd_addr[i]!=0 and any occupied entry has gr_we && !ex && dest==fwd_addr[i]; fwd_data[i] SHALL be the youngest such entry's result, else 0.
REQ-029 Forward lookup SHALL include entries retiring this cycle and exclude the same-cycle push.
REQ-030 retired_cnt SHALL increment by the number of retiring entries without ex/ertn set, wrapping at 2^64.
REQ-031 debug_wb_* slot k SHALL mirror retiring pc, {4{rf_we[k]}}, dest, result; all zero for non-retiring slots.

Reset
REQ-032 reset SHALL clear pointers, count, entry valid bits and retired_cnt; outputs after reset: in_ready=1, rf_we=0, flush=0, fwd_hit=0, debug_wb_rf_wen=0.
REQ-033 reset SHALL override push, retire and flush in the same cycle; a mid-operation reset discards all queued entries.

Verification
REQ-034 DEPTH=4: push 5 entries with commit_stall=1 -> 4 accepted, in_ready=0 on 5th; release stall -> retire in order, in_ready=1 next cycle.
REQ-035 COMMIT_W=2: queue {pc 0x1c000000 dest 3 =0x11, pc 0x1c000004 dest 3 =0x22} -> same cycle rf_we=2'b10, r3=0x22, retired_cnt +=2.
REQ-036 Queue {A normal, B in_ex ecode 0x08 pc 0x1c000010, C normal} -> A retires, next cycle flush=1 flush_pc=0x1c000010 ecode 0x08, B no rf write, C discarded, count=0.
REQ-037 Entries dest 5 =0xAA then dest 5 =0xBB queued, fwd_addr=5 -> fwd_hit=1, fwd_data=0xBB; fwd_addr=0 -> fwd_hit=0.
REQ-038 Wrap: 10 push/retire cycles at DEPTH=4 -> FIFO order preserved across pointer wrap; reset asserted with 3 queued -> count=0, rf_we=0 next cycle.
